mcu_n: RTL and testbench
========================

MCU_N -- requirements
Module: mcu_n

Interface
REQ-001 SHALL have parameter NUM_SONGS, default 4: number of tracks; legal range 2..256.
REQ-002 SHALL have parameter SONG_BITS, default 2: width of song; SONG_BITS >= ceil(log2(NUM_SONGS)).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port play_pause, input, 1 bit: one-cycle pulse that toggles play/pause.
REQ-006 SHALL have port next, input, 1 bit: one-cycle pulse that selects the next track.
REQ-007 SHALL have port prev, input, 1 bit: one-cycle pulse that selects the previous track (see Configuration).
REQ-008 SHALL have port song_done, input, 1 bit: one-cycle pulse from the player marking the end of the current track.
REQ-009 SHALL have port mode, input, 2 bits: 0 = loop all, 1 = repeat one, 2 = stop at end, 3 = treated as 0.
REQ-010 SHALL have port play, output, 1 bit: 1 while the track is playing.
REQ-011 SHALL have port song, output, SONG_BITS bits: current track index, range 0..NUM_SONGS-1.
REQ-012 SHALL have port reset_play, output, 1 bit: restarts the player at the start of the track.

Function
REQ-013 SHALL implement an FSM with states INIT, PAUSED, PLAYING, ADVANCE, RETREAT, RESTART; all outputs registered.
REQ-014 SHALL hold INIT for exactly one cycle after reset release, with reset_play=1 and play=0, then go to PAUSED.
REQ-015 SHALL drive play=1 only in PLAYING; play=0 in every other state.
REQ-016 SHALL drive reset_play=1 in INIT, ADVANCE, RETREAT and RESTART, and 0 otherwise.
REQ-017 SHALL apply input priority per cycle: next > prev > song_done > play_pause; lower-priority pulses in the same cycle are dropped.
REQ-018 PAUSED: play_pause -> PLAYING; next -> ADVANCE; prev -> RETREAT; song_done is ignored.
REQ-019 PLAYING: play_pause -> PAUSED; next -> ADVANCE; prev -> RETREAT; song_done is handled per REQ-022..024.
REQ-020 ADVANCE/RETREAT SHALL last one cycle, with song += 1 / -= 1 modulo NUM_SONGS (NUM_SONGS-1 -> 0, 0 -> NUM_SONGS-1) on entry, then return to the play state (PAUSED or PLAYING) held before entry.
REQ-021 SHALL ignore all pulses that arrive during INIT, ADVANCE, RETREAT or RESTART.
REQ-022 mode 0 on song_done: ADVANCE, then return to PLAYING, wrapping at the last track.
REQ-023 mode 1 on song_done: RESTART for one cycle with song unchanged, then return to PLAYING.
REQ-024 mode 2 on song_done: ADVANCE; if the old song was NUM_SONGS-1, song becomes 0 and the FSM returns to PAUSED, else it returns to PLAYING.
REQ-025 SHALL sample mode only on the song_done cycle; mode changes at other times have no effect.
REQ-026 song SHALL never leave 0..NUM_SONGS-1, including when NUM_SONGS is not a power of two.

Reset
REQ-027 reset=1 SHALL force state INIT, song=0, play=0, reset_play=1 immediately and hold these while asserted.
REQ-028 reset asserted mid-ADVANCE/RETREAT SHALL abort the step, with song=0 and no partial update visible.

Configuration
REQ-029 Macro MCU_N_PREV_EN defined: the prev input and the RETREAT state are implemented as in REQ-018..020.
REQ-030 MCU_N_PREV_EN undefined: the prev port remains but is ignored, RETREAT is unreachable, and the logic is removed.

Verification
REQ-031 NUM_SONGS=5: reset, then 5 next pulses while PAUSED -> song 1,2,3,4,0, each with a one-cycle reset_play pulse, and play stays 0.
REQ-032 PLAYING, mode=2, song=4 (NUM_SONGS=5), song_done -> song=0, play=0 after 2 cycles; with song=2 -> song=3, play=1.
REQ-033 PLAYING, mode=1, song=3, song_done -> reset_play=1 for 1 cycle, song=3, play=1 throughout except the RESTART cycle.
REQ-034 With MCU_N_PREV_EN defined, song=0, prev -> song=NUM_SONGS-1; with it undefined, prev has no effect.
REQ-035 next and play_pause in the same cycle while PLAYING -> song+1, play=1 after ADVANCE (play_pause dropped).
REQ-036 Assert reset during an ADVANCE cycle -> song=0, play=0, reset_play=1 asynchronously; after release, INIT for 1 cycle, then PAUSED.

Source files
------------

// File: rtl/mcu_n.sv
// Track-selection controller for a simple music player: play/pause, next/prev and end-of-track handling.
// Optional feature: define MCU_N_PREV_EN to implement the prev input and the RETREAT state.
module mcu_n #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_pause,
    input  logic                 next,
    input  logic                 prev,
    input  logic                 song_done,
    input  logic [1:0]           mode,
    output logic                 play,
    output logic [SONG_BITS-1:0] song,
    output logic                 reset_play
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        PAUSED  = 3'd1,
        PLAYING = 3'd2,
        ADVANCE = 3'd3,
        RETREAT = 3'd4,
        RESTART = 3'd5
    } state_t;

    localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);
    localparam logic [SONG_BITS-1:0] ONE_SONG  = SONG_BITS'(1);
    localparam logic [SONG_BITS-1:0] ZERO_SONG = SONG_BITS'(0);

    state_t               state_r;
    state_t               resume_r;
    logic [SONG_BITS-1:0] song_r;
    logic                 play_r;
    logic                 reset_play_r;
    logic                 prev_s;

    // Explicit compare-and-wrap keeps the index legal for non-power-of-two track counts.
    function automatic logic [SONG_BITS-1:0] song_inc(input logic [SONG_BITS-1:0] cur);
        if (cur == LAST_SONG) begin
            song_inc = ZERO_SONG;
        end else begin
            song_inc = cur + ONE_SONG;
        end
    endfunction

`ifdef MCU_N_PREV_EN
    function automatic logic [SONG_BITS-1:0] song_dec(input logic [SONG_BITS-1:0] cur);
        if (cur == ZERO_SONG) begin
            song_dec = LAST_SONG;
        end else begin
            song_dec = cur - ONE_SONG;
        end
    endfunction

    assign prev_s = prev;
`else
    logic prev_unused_s;

    assign prev_s        = 1'b0;
    assign prev_unused_s = prev;
`endif

    // Single state machine; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= INIT;
            resume_r     <= PAUSED;
            song_r       <= ZERO_SONG;
            play_r       <= 1'b0;
            reset_play_r <= 1'b1;
        end else begin
            case (state_r)
                INIT: begin
                    state_r      <= PAUSED;
                    play_r       <= 1'b0;
                    reset_play_r <= 1'b0;
                end
                PAUSED, PLAYING: begin
                    if (next) begin
                        state_r      <= ADVANCE;
                        resume_r     <= state_r;
                        song_r       <= song_inc(song_r);
                        play_r       <= 1'b0;
                        reset_play_r <= 1'b1;
`ifdef MCU_N_PREV_EN
                    end else if (prev_s) begin
                        state_r      <= RETREAT;
                        resume_r     <= state_r;
                        song_r       <= song_dec(song_r);
                        play_r       <= 1'b0;
                        reset_play_r <= 1'b1;
`endif
                    end else if (song_done && (state_r == PLAYING)) begin
                        play_r       <= 1'b0;
                        reset_play_r <= 1'b1;
                        case (mode)
                            2'd1: begin
                                state_r  <= RESTART;
                                resume_r <= PLAYING;
                            end
                            2'd2: begin
                                // Stop-at-end: wrapping past the last track lands paused on track 0.
                                state_r  <= ADVANCE;
                                song_r   <= song_inc(song_r);
                                resume_r <= (song_r == LAST_SONG) ? PAUSED : PLAYING;
                            end
                            default: begin
                                state_r  <= ADVANCE;
                                song_r   <= song_inc(song_r);
                                resume_r <= PLAYING;
                            end
                        endcase
                    end else if (play_pause) begin
                        state_r      <= (state_r == PLAYING) ? PAUSED : PLAYING;
                        play_r       <= (state_r == PAUSED);
                        reset_play_r <= 1'b0;
                    end else begin
                        play_r       <= (state_r == PLAYING);
                        reset_play_r <= 1'b0;
                    end
                end
                ADVANCE, RETREAT, RESTART: begin
                    state_r      <= resume_r;
                    play_r       <= (resume_r == PLAYING);
                    reset_play_r <= 1'b0;
                end
                default: begin
                    state_r      <= INIT;
                    resume_r     <= PAUSED;
                    song_r       <= ZERO_SONG;
                    play_r       <= 1'b0;
                    reset_play_r <= 1'b1;
                end
            endcase
        end
    end

    assign play       = play_r;
    assign song       = song_r;
    assign reset_play = reset_play_r;

endmodule

// File: tb/tb_mcu_n.sv
// Directed self-checking bench for mcu_n with five tracks; expectations follow MCU_N_PREV_EN if defined.
module tb_mcu_n;

    logic       clk;
    logic       reset;
    logic       play_pause;
    logic       next;
    logic       prev;
    logic       song_done;
    logic [1:0] mode;
    logic       play;
    logic [2:0] song;
    logic       reset_play;

    int total;
    int bad;

    mcu_n #(.NUM_SONGS(5), .SONG_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (play_pause),
        .next       (next),
        .prev       (prev),
        .song_done  (song_done),
        .mode       (mode),
        .play       (play),
        .song       (song),
        .reset_play (reset_play)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] es, input logic ep, input logic er);
        chk({tag, ".song"}, {29'd0, song}, {29'd0, es});
        chk({tag, ".play"}, {31'd0, play}, {31'd0, ep});
        chk({tag, ".rp"}, {31'd0, reset_play}, {31'd0, er});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        play_pause = 1'b0;
        next       = 1'b0;
        prev       = 1'b0;
        song_done  = 1'b0;
        mode       = 2'd0;
        step();
        chk3("rst_hold", 3'd0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        #1;
        chk3("init", 3'd0, 1'b0, 1'b1);
        step();
        chk3("paused", 3'd0, 1'b0, 1'b0);

        // Five next pulses while paused walk 1,2,3,4,0.
        for (int k = 1; k <= 5; k++) begin
            next = 1'b1;
            step();
            next = 1'b0;
            chk3($sformatf("adv%0d", k), 3'(k % 5), 1'b0, 1'b1);
            step();
            chk3($sformatf("adv%0d_done", k), 3'(k % 5), 1'b0, 1'b0);
        end

        play_pause = 1'b1; step(); play_pause = 1'b0;
        chk3("play", 3'd0, 1'b1, 1'b0);

        // next wins over play_pause in the same cycle.
        next = 1'b1; play_pause = 1'b1; step(); next = 1'b0; play_pause = 1'b0;
        chk3("np_adv", 3'd1, 1'b0, 1'b1);
        step();
        chk3("np_done", 3'd1, 1'b1, 1'b0);

        next = 1'b1; step(); next = 1'b0; step();
        chk3("to2", 3'd2, 1'b1, 1'b0);

        mode = 2'd2; song_done = 1'b1; step(); song_done = 1'b0; mode = 2'd1;
        chk3("m2_mid_adv", 3'd3, 1'b0, 1'b1);
        step();
        chk3("m2_mid_done", 3'd3, 1'b1, 1'b0);
        mode = 2'd0;

        next = 1'b1; step(); next = 1'b0; step();
        chk3("to4", 3'd4, 1'b1, 1'b0);
        mode = 2'd2; song_done = 1'b1; step(); song_done = 1'b0; mode = 2'd0;
        chk3("m2_end_adv", 3'd0, 1'b0, 1'b1);
        step();
        chk3("m2_end_done", 3'd0, 1'b0, 1'b0);

        play_pause = 1'b1; step(); play_pause = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next = 1'b1; step(); next = 1'b0; step();
        end
        chk3("to3", 3'd3, 1'b1, 1'b0);
        mode = 2'd1; song_done = 1'b1; step(); song_done = 1'b0;
        chk3("m1_restart", 3'd3, 1'b0, 1'b1);
        step();
        chk3("m1_done", 3'd3, 1'b1, 1'b0);
        step();
        chk3("m1_no_sd", 3'd3, 1'b1, 1'b0);

        next = 1'b1; step(); next = 1'b0; step();
        mode = 2'd0; song_done = 1'b1; step(); song_done = 1'b0;
        chk3("m0_wrap_adv", 3'd0, 1'b0, 1'b1);
        step();
        chk3("m0_wrap_done", 3'd0, 1'b1, 1'b0);

        // mode 3 behaves as loop-all; play_pause during ADVANCE is ignored.
        mode = 2'd3; song_done = 1'b1; step(); song_done = 1'b0; mode = 2'd0;
        play_pause = 1'b1; step(); play_pause = 1'b0;
        chk3("m3_ign_pp", 3'd1, 1'b1, 1'b0);

        play_pause = 1'b1; step(); play_pause = 1'b0;
        chk3("pause", 3'd1, 1'b0, 1'b0);
        song_done = 1'b1; step(); song_done = 1'b0;
        chk3("sd_paused", 3'd1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            next = 1'b1; step(); next = 1'b0; step();
        end
        chk3("back0", 3'd0, 1'b0, 1'b0);

        prev = 1'b1; step(); prev = 1'b0;
`ifdef MCU_N_PREV_EN
        chk3("prev_ret", 3'd4, 1'b0, 1'b1);
        step();
        chk3("prev_done", 3'd4, 1'b0, 1'b0);
        next = 1'b1; prev = 1'b1; step(); next = 1'b0; prev = 1'b0;
        chk3("np_prio", 3'd0, 1'b0, 1'b1);
        step();
        chk3("np_prio_done", 3'd0, 1'b0, 1'b0);
`else
        chk3("prev_ign", 3'd0, 1'b0, 1'b0);
        step();
        chk3("prev_ign2", 3'd0, 1'b0, 1'b0);
        next = 1'b1; prev = 1'b1; step(); next = 1'b0; prev = 1'b0;
        chk3("np_prio", 3'd1, 1'b0, 1'b1);
        step();
        chk3("np_prio_done", 3'd1, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of an ADVANCE cycle.
        play_pause = 1'b1; step(); play_pause = 1'b0;
        next = 1'b1; step(); next = 1'b0;
        chk("adv_before_rst.rp", {31'd0, reset_play}, 32'd1);
        reset = 1'b1;
        #1;
        chk3("rst_async", 3'd0, 1'b0, 1'b1);
        step();
        chk3("rst_held", 3'd0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        chk3("rst_init", 3'd0, 1'b0, 1'b1);
        step();
        chk3("rst_paused", 3'd0, 1'b0, 1'b0);
        play_pause = 1'b1; step(); play_pause = 1'b0;
        chk3("rst_play", 3'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
